// File: rtl/ucisc_pkg.sv
// rtl/ucisc_pkg.sv - shared uCISC result-writer state encoding and offset width
package ucisc_pkg;

   localparam int OFFSET_WIDTH = 4;

   typedef enum logic [1:0] {
      RW_IDLE  = 2'd0,
      RW_ISSUE = 2'd1,
      RW_DONE  = 2'd2
   } rw_state_e;

endpackage

// File: rtl/result_writer_if.sv
// rtl/result_writer_if.sv - single-beat memory write port of the result writer
interface result_writer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] mem_address;
   logic [WIDTH-1:0] mem_data_out;
   logic             mem_write;
   logic             mem_ready;

   modport master (
      output mem_address,
      output mem_data_out,
      output mem_write,
      input  mem_ready
   );

   modport slave (
      input  mem_address,
      input  mem_data_out,
      input  mem_write,
      output mem_ready
   );
endinterface

// File: rtl/address_resolver.sv
// rtl/address_resolver.sv - destination address and new base from base/offset/increment
// Optional pre-decrement push selected by macro RESULT_WRITER_PUSH_EN.
module address_resolver
   import ucisc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]        base_i,
   input  logic [OFFSET_WIDTH-1:0] offset_i,
   input  logic                    increment_i,
   output logic [WIDTH-1:0]        address_o,
   output logic [WIDTH-1:0]        updated_base_o
);

   logic [WIDTH-1:0] offset_address;

   // Offset is zero-extended; the sum wraps naturally at WIDTH bits.
   assign offset_address = base_i + {{(WIDTH-OFFSET_WIDTH){1'b0}}, offset_i};

`ifdef RESULT_WRITER_PUSH_EN
   logic [WIDTH-1:0] pushed_address;

   assign pushed_address = base_i - {{(WIDTH-1){1'b0}}, 1'b1};
   assign address_o      = increment_i ? pushed_address : offset_address;
   assign updated_base_o = increment_i ? pushed_address : base_i;
`else
   logic unused_increment;

   assign unused_increment = increment_i;
   assign address_o        = offset_address;
   assign updated_base_o   = base_i;
`endif

endmodule

// File: rtl/result_writer.sv
// rtl/result_writer.sv - stores a finished result word to memory and reports completion
// Push addressing is enabled with macro RESULT_WRITER_PUSH_EN (see address_resolver).
module result_writer
   import ucisc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [WIDTH-1:0]        value,
   input  logic [WIDTH-1:0]        base_address,
   input  logic [OFFSET_WIDTH-1:0] offset,
   input  logic                    destination_mem,
   input  logic                    increment,
   result_writer_if.master         mem,
   output logic [WIDTH-1:0]        updated_base,
   output logic                    busy,
   output logic                    done
);

   rw_state_e        state_q, state_d;
   logic [WIDTH-1:0] address_q, address_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] resolved_address;
   logic [WIDTH-1:0] resolved_base;
   logic             write_o;
   logic             busy_o;
   logic             done_o;

   // Push mode only makes sense for a memory destination.
   address_resolver #(
      .WIDTH (WIDTH)
   ) u_address_resolver (
      .base_i         (base_address),
      .offset_i       (offset),
      .increment_i    (increment & destination_mem),
      .address_o      (resolved_address),
      .updated_base_o (resolved_base)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RW_IDLE;
         address_q <= '0;
         data_q    <= '0;
         base_q    <= '0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         data_q    <= data_d;
         base_q    <= base_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      data_d    = data_q;
      base_d    = base_q;
      write_o   = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state_q)
         RW_IDLE: begin
            busy_o = 1'b0;
            if (start) begin
               if (destination_mem) begin
                  address_d = resolved_address;
                  data_d    = value;
                  base_d    = resolved_base;
                  state_d   = RW_ISSUE;
               end else begin
                  base_d  = base_address;
                  state_d = RW_DONE;
               end
            end
         end
         RW_ISSUE: begin
            write_o = 1'b1;
            if (mem.mem_ready) begin
               state_d = RW_DONE;
            end
         end
         RW_DONE: begin
            done_o  = 1'b1;
            state_d = RW_IDLE;
         end
         default: begin
            state_d = RW_IDLE;
         end
      endcase
   end

   // Strobe is decoded from state so reset removes it without a clock edge.
   assign mem.mem_write    = write_o;
   assign mem.mem_address  = address_q;
   assign mem.mem_data_out = data_q;
   assign updated_base     = base_q;
   assign busy             = busy_o;
   assign done             = done_o;

endmodule

// File: doc/result_writer.md
# result_writer

Store-side counterpart to the immediate loader in the uCISC reference core: where the loader fetches the word at `pc + 1` into the datapath, this block takes a finished 16-bit result and writes it to memory. It resolves the destination address from a base register plus a 4-bit offset, drives a single-beat memory write with a ready handshake, and reports completion to the step sequencer. When the destination is a register rather than memory, it completes without touching memory.

## Interface
Parameters:
- `WIDTH`, 16: data and address width.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `value`  in  WIDTH  result word to store.
- `base_address`  in  WIDTH  destination register contents.
- `offset`  in  4  word offset, zero-extended.
- `destination_mem`  in  1  1 = write to memory; 0 = register destination, no memory access.
- `increment`  in  1  push request (see Configuration).
- `mem_ready`  in  1  memory accepts the write this cycle.
- `mem_address`  out  WIDTH  write address.
- `mem_data_out`  out  WIDTH  write data.
- `mem_write`  out  1  write strobe; held until accepted.
- `updated_base`  out  WIDTH  new base register value.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE + `start` + `destination_mem=1`:
  - latch `mem_data_out <= value`;
  - latch `mem_address <= base_address + offset`, computed mod 2^16;
  - latch `updated_base`;
  - go to ISSUE.
- IDLE + `start` + `destination_mem=0`: no write, `updated_base <= base_address`; go to DONE.
- ISSUE: `mem_write=1`, address and data stable. When `mem_ready=1` is sampled → DONE. Otherwise stay in ISSUE; wait time is unbounded.
- DONE: `done=1` for exactly one cycle, `mem_write=0` → IDLE.
- A `start` asserted while `busy=1` is ignored, not queued.
- Address arithmetic wraps: base 0xFFFE + offset 3 → 0x0001.
- `updated_base` holds its last value until the next accepted `start`.

## Timing
- Reset (asynchronous assert): state IDLE; `mem_write`, `busy`, `done`, `mem_address`, `mem_data_out`, `updated_base` all 0. `mem_write` drops immediately without waiting for a clock edge.
- Reset deassertion is synchronized externally; the block does not re-synchronize it.
- Memory path: `start` at cycle 0 → `mem_write` high from cycle 1 → with `mem_ready` high at cycle 1, `done` at cycle 2, and `start` is accepted again at cycle 3. Minimum throughput is one write per 3 cycles.
- Register path: `start` at cycle 0 → `done` at cycle 1.
- `mem_ready` high outside ISSUE has no effect.
- Reset during ISSUE aborts the write; no `done` pulse is produced.

## Configuration
- `RESULT_WRITER_PUSH_EN` defined:
  - `increment=1` with `destination_mem=1` selects pre-decrement push;
  - `mem_address = updated_base = base_address - 1`, with wrap 0x0000 → 0xFFFF;
  - `offset` is ignored in this mode.
- `RESULT_WRITER_PUSH_EN` not defined: `increment` is ignored, the address is always `base + offset`, and `updated_base = base_address`.

## Structure
- Shared package `ucisc_pkg` holds:
  - the state encoding constants `RW_IDLE=2'd0`, `RW_ISSUE=2'd1`, `RW_DONE=2'd2`;
  - the offset width constant `OFFSET_WIDTH=4`.
- One natural sub-module, `address_resolver`: combinational, computing the next address and `updated_base` from base, offset, and increment. It contains the only code under `RESULT_WRITER_PUSH_EN`.
- The FSM and output registers live in `result_writer`.

## Test plan
- Reset mid-ISSUE: with `mem_ready=0`, assert `reset_n=0` during ISSUE → `mem_write` falls the same cycle, and no `done` pulse appears after release.
- Basic store: base 0x1000, offset 3, value 0xBEEF, `mem_ready` tied high → `mem_write` at cycle 1 with address 0x1003 and data 0xBEEF, `done` at cycle 2, `busy` low at cycle 3.
- Stalled store: hold `mem_ready=0` for 5 cycles → `mem_write` and address/data stable for 6 cycles, then a single `done`; a `start` pulsed during the stall is ignored.
- Register destination: `destination_mem=0`, base 0x0042 → no `mem_write`, `done` at cycle 1, `updated_base=0x0042`.
- Wrap: base 0xFFFE, offset 3 → `mem_address=0x0001`.
- Push with `RESULT_WRITER_PUSH_EN` defined: base 0x0000, `increment=1`, offset 7 → `mem_address=0xFFFF`, `updated_base=0xFFFF`.
- Push with the macro undefined: same stimulus → `mem_address=0x0007`, `updated_base=0x0000`.
